// File: rtl/path_executor_if.sv
`default_nettype none
// ============================================================================
// Module      : path_executor_if
// Description : Route, node and turn-handshake signals of the path executor.
// Revision    : 1.0 - initial release
// ============================================================================
interface path_executor_if #(
    parameter int MAX_STEPS = 10,
    parameter int DIR_W     = 3
);
    logic [MAX_STEPS*DIR_W-1:0] dir_flat;
    logic [3:0]                 len_in;
    logic                       path_valid;
    logic                       path_ready;
    logic                       node_detect;
    logic                       follow_en;
    logic [DIR_W-1:0]           turn_cmd;
    logic                       turn_valid;
    logic                       turn_done;
    logic [3:0]                 step_idx;
    logic                       busy;
    logic                       run_done;
    logic                       err;

    // Executor side.
    modport slave (
        input  dir_flat, len_in, path_valid, node_detect, turn_done,
        output path_ready, follow_en, turn_cmd, turn_valid, step_idx, busy, run_done, err
    );

    // Planner / sensor / motor side.
    modport master (
        output dir_flat, len_in, path_valid, node_detect, turn_done,
        input  path_ready, follow_en, turn_cmd, turn_valid, step_idx, busy, run_done, err
    );
endinterface
`default_nettype wire

// File: rtl/path_executor.sv
`default_nettype none
// ============================================================================
// Module      : path_executor
// Description : Walks a planned turn list one slot per detected node and hands
//               turns to the motor controller. Optional turn watchdog is
//               enabled by defining PATH_EXEC_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module path_executor #(
    parameter int MAX_STEPS = 10,
    parameter int DIR_W     = 3
`ifdef PATH_EXEC_TIMEOUT_EN
    ,
    parameter int TURN_TIMEOUT = 50_000_000
`endif
) (
    input  wire            clk,
    input  wire            reset,
    path_executor_if.slave bus
);
    localparam int               c_FLAT_W   = MAX_STEPS * DIR_W;
    localparam logic [3:0]       c_MAX_LEN  = 4'(MAX_STEPS);
    localparam logic [DIR_W-1:0] c_STRAIGHT = DIR_W'(0);
    localparam logic [DIR_W-1:0] c_STOP     = DIR_W'(4);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FOLLOW    = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_TURN = 3'd3,
        S_DONE      = 3'd4,
        S_ERROR     = 3'd5
    } state_t;

    state_t               r_state;
    logic [c_FLAT_W-1:0]  r_codes;
    logic [3:0]           r_len;
    logic [3:0]           r_step;
    logic                 r_path_ready;
    logic                 r_follow_en;
    logic [DIR_W-1:0]     r_turn_cmd;
    logic                 r_turn_valid;
    logic                 r_busy;
    logic                 r_run_done;
    logic                 r_err;

    logic [3:0]           w_len_clamped;
    logic [DIR_W-1:0]     w_cur_code;

`ifdef PATH_EXEC_TIMEOUT_EN
    localparam int                c_TO_W    = $clog2(TURN_TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TURN_TIMEOUT - 1);
    logic [c_TO_W-1:0]    r_to_cnt;
`endif

    assign w_len_clamped = (bus.len_in > c_MAX_LEN) ? c_MAX_LEN : bus.len_in;
    // Only read in ISSUE, where r_step < r_len <= MAX_STEPS.
    assign w_cur_code    = r_codes[int'(r_step) * DIR_W +: DIR_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_codes      <= '0;
            r_len        <= '0;
            r_step       <= '0;
            r_path_ready <= 1'b1;
            r_follow_en  <= 1'b0;
            r_turn_cmd   <= '0;
            r_turn_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_run_done   <= 1'b0;
            r_err        <= 1'b0;
`ifdef PATH_EXEC_TIMEOUT_EN
            r_to_cnt     <= '0;
`endif
        end else begin
            r_run_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.path_valid) begin
                        r_codes      <= bus.dir_flat;
                        r_len        <= w_len_clamped;
                        r_step       <= '0;
                        r_err        <= 1'b0;
                        r_path_ready <= 1'b0;
                        if (w_len_clamped == 4'd0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state     <= S_FOLLOW;
                            r_follow_en <= 1'b1;
                            r_busy      <= 1'b1;
                        end
                    end
                end

                S_FOLLOW: begin
                    if (bus.node_detect) begin
                        if (r_step == r_len) begin
                            r_state     <= S_DONE;
                            r_follow_en <= 1'b0;
                            r_busy      <= 1'b0;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    if (w_cur_code == c_STRAIGHT) begin
                        r_step  <= r_step + 4'd1;
                        r_state <= S_FOLLOW;
                    end else if (w_cur_code == c_STOP) begin
                        r_state     <= S_DONE;
                        r_follow_en <= 1'b0;
                        r_busy      <= 1'b0;
                    end else if (w_cur_code > c_STOP) begin
                        r_state     <= S_ERROR;
                        r_err       <= 1'b1;
                        r_follow_en <= 1'b0;
                        r_busy      <= 1'b0;
                    end else begin
                        r_state      <= S_WAIT_TURN;
                        r_turn_cmd   <= w_cur_code;
                        r_turn_valid <= 1'b1;
                        r_follow_en  <= 1'b0;
`ifdef PATH_EXEC_TIMEOUT_EN
                        r_to_cnt     <= '0;
`endif
                    end
                end

                S_WAIT_TURN: begin
                    if (bus.turn_done) begin
                        r_state      <= S_FOLLOW;
                        r_turn_valid <= 1'b0;
                        r_turn_cmd   <= '0;
                        r_step       <= r_step + 4'd1;
                        r_follow_en  <= 1'b1;
                    end
`ifdef PATH_EXEC_TIMEOUT_EN
                    else if (r_to_cnt == c_TO_LAST) begin
                        r_state      <= S_ERROR;
                        r_turn_valid <= 1'b0;
                        r_turn_cmd   <= '0;
                        r_err        <= 1'b1;
                        r_busy       <= 1'b0;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_TO_W'(1);
                    end
`endif
                end

                S_DONE: begin
                    r_run_done   <= 1'b1;
                    r_path_ready <= 1'b1;
                    r_state      <= S_IDLE;
                end

                S_ERROR: begin
                    r_path_ready <= 1'b1;
                    r_state      <= S_IDLE;
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_path_ready <= 1'b1;
                    r_follow_en  <= 1'b0;
                    r_turn_valid <= 1'b0;
                    r_turn_cmd   <= '0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.path_ready = r_path_ready;
    assign bus.follow_en  = r_follow_en;
    assign bus.turn_cmd   = r_turn_cmd;
    assign bus.turn_valid = r_turn_valid;
    assign bus.step_idx   = r_step;
    assign bus.busy       = r_busy;
    assign bus.run_done   = r_run_done;
    assign bus.err        = r_err;
endmodule
`default_nettype wire

// File: tb/tb_path_executor.sv
`default_nettype none
// ============================================================================
// Module      : tb_path_executor
// Description : Directed and random routes for path_executor against a
//               route-walking reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_path_executor;
    localparam int MAX_STEPS = 10;
    localparam int DIR_W     = 3;
    localparam int FW        = MAX_STEPS * DIR_W;

    logic clk = 1'b0;
    logic reset;

    path_executor_if #(.MAX_STEPS(MAX_STEPS), .DIR_W(DIR_W)) bus ();

    path_executor #(.MAX_STEPS(MAX_STEPS), .DIR_W(DIR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_pass   = 0;
    string cur      = "init";

    // Passive observation of turn requests and status pulses.
    int   mon_turns[$];
    int   mon_run_done = 0;
    int   mon_follow   = 0;
    int   mon_busy     = 0;
    logic prev_tv      = 1'b0;

    always @(negedge clk) begin
        if (bus.turn_valid && !prev_tv) mon_turns.push_back(int'(bus.turn_cmd));
        prev_tv = bus.turn_valid;
        if (bus.run_done)  mon_run_done++;
        if (bus.follow_en) mon_follow++;
        if (bus.busy)      mon_busy++;
    end

    // Reference model: what a route should do, walked slot by slot.
    int exp_turns[$];
    int exp_nodes;
    int exp_step;
    int exp_lq;
    bit exp_err;

    function automatic int slot(input logic [FW-1:0] f, input int k);
        return int'(f[k*DIR_W +: DIR_W]);
    endfunction

    function automatic logic [FW-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [FW-1:0] f;
        for (int k = 0; k < MAX_STEPS; k++) f[k*DIR_W +: DIR_W] = 3'd5;
        f[0*DIR_W +: DIR_W] = DIR_W'(a);
        f[1*DIR_W +: DIR_W] = DIR_W'(b);
        f[2*DIR_W +: DIR_W] = DIR_W'(c);
        f[3*DIR_W +: DIR_W] = DIR_W'(d);
        return f;
    endfunction

    task automatic model(input logic [FW-1:0] flat, input logic [3:0] len);
        int c;
        exp_turns.delete();
        exp_lq    = (int'(len) > MAX_STEPS) ? MAX_STEPS : int'(len);
        exp_err   = 1'b0;
        exp_nodes = 0;
        exp_step  = 0;
        if (exp_lq == 0) return;
        for (int k = 0; k < exp_lq; k++) begin
            c = slot(flat, k);
            exp_nodes++;
            if (c == 4) begin exp_step = k; return; end
            if (c >= 5) begin exp_step = k; exp_err = 1'b1; return; end
            if (c != 0) exp_turns.push_back(c);
        end
        exp_nodes++;
        exp_step = exp_lq;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s.%s observed=%0d expected=%0d", cur, tag, obs, exp);
    endtask

    task automatic run_route(input logic [FW-1:0] flat, input logic [3:0] len,
                             input int d, input bit hold, input bit poke);
        int  t0, rd0, fe0, bu0, c;
        bit  poked;
        poked = 1'b0;
        model(flat, len);
        t0  = mon_turns.size();
        rd0 = mon_run_done;
        fe0 = mon_follow;
        bu0 = mon_busy;
        chk("idle_ready", bus.path_ready, 1);
        bus.turn_done  = hold;
        bus.dir_flat   = flat;
        bus.len_in     = len;
        bus.path_valid = 1'b1;
        tick();
        bus.path_valid = 1'b0;
        chk("acc_ready", bus.path_ready, 0);
        chk("acc_err", bus.err, 0);
        chk("acc_step", bus.step_idx, 0);
        chk("acc_follow", bus.follow_en, exp_lq != 0);
        if (exp_lq == 0) begin
            chk("len0_rd_early", bus.run_done, 0);
            tick();
            chk("len0_rd", bus.run_done, 1);
        end
        for (int n = 0; n < exp_nodes; n++) begin
            bus.node_detect = 1'b1;
            tick();
            bus.node_detect = 1'b0;
            tick();
            if (n == exp_lq) begin
                chk("end_rd", bus.run_done, 1);
                chk("end_busy", bus.busy, 0);
            end else begin
                c = slot(flat, n);
                if (c >= 1 && c <= 3) begin
                    chk("turn_valid", bus.turn_valid, 1);
                    chk("turn_cmd", bus.turn_cmd, c);
                    chk("turn_follow", bus.follow_en, 0);
                    if (poke && !poked) begin
                        poked           = 1'b1;
                        bus.node_detect = 1'b1;
                        bus.path_valid  = 1'b1;
                        bus.dir_flat    = ~flat;
                        bus.len_in      = 4'd1;
                        tick();
                        bus.node_detect = 1'b0;
                        bus.path_valid  = 1'b0;
                        chk("poke_step", bus.step_idx, n);
                        chk("poke_tv", bus.turn_valid, 1);
                        chk("poke_ready", bus.path_ready, 0);
                    end
                    if (!hold) begin
                        repeat (d) begin
                            tick();
                            chk("hold_tv", bus.turn_valid, 1);
                            chk("hold_cmd", bus.turn_cmd, c);
                        end
                        bus.turn_done = 1'b1;
                    end
                    tick();
                    if (!hold) bus.turn_done = 1'b0;
                    chk("drop_tv", bus.turn_valid, 0);
                    chk("drop_cmd", bus.turn_cmd, 0);
                    chk("turn_step", bus.step_idx, n + 1);
                    chk("turn_follow_back", bus.follow_en, 1);
                end else if (c == 0) begin
                    chk("str_tv", bus.turn_valid, 0);
                    chk("str_step", bus.step_idx, n + 1);
                    chk("str_follow", bus.follow_en, 1);
                end else if (c == 4) begin
                    chk("stop_rd_early", bus.run_done, 0);
                    tick();
                    chk("stop_rd", bus.run_done, 1);
                end else begin
                    chk("bad_err", bus.err, 1);
                    chk("bad_ready_early", bus.path_ready, 0);
                    tick();
                    chk("bad_ready", bus.path_ready, 1);
                end
            end
        end
        repeat (3) tick();
        bus.turn_done = 1'b0;
        chk("rd_count", mon_run_done - rd0, exp_err ? 0 : 1);
        chk("turn_count", mon_turns.size() - t0, exp_turns.size());
        for (int i = 0; i < exp_turns.size() && t0 + i < mon_turns.size(); i++)
            chk("turn_seq", mon_turns[t0 + i], exp_turns[i]);
        chk("final_step", bus.step_idx, exp_step);
        chk("final_err", bus.err, exp_err);
        chk("final_ready", bus.path_ready, 1);
        chk("final_busy", bus.busy, 0);
        chk("final_follow", bus.follow_en, 0);
        chk("follow_seen", (mon_follow - fe0) > 0, exp_lq != 0);
        chk("busy_seen", (mon_busy - bu0) > 0, exp_lq != 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [FW-1:0] f;
        int            p;
        int            cc;
        reset           = 1'b1;
        bus.dir_flat    = '0;
        bus.len_in      = '0;
        bus.path_valid  = 1'b0;
        bus.node_detect = 1'b0;
        bus.turn_done   = 1'b0;
        repeat (3) tick();
        cur = "reset";
        chk("ready", bus.path_ready, 1);
        chk("follow", bus.follow_en, 0);
        chk("cmd", bus.turn_cmd, 0);
        chk("tv", bus.turn_valid, 0);
        chk("step", bus.step_idx, 0);
        chk("busy", bus.busy, 0);
        chk("rd", bus.run_done, 0);
        chk("err", bus.err, 0);
        reset = 1'b0;
        tick();

        cur = "plan_a";   run_route(pack4(2, 0, 3, 4), 4'd4, 5, 1'b0, 1'b0);
        cur = "len0";     run_route('0, 4'd0, 1, 1'b0, 1'b0);
        cur = "hold";     run_route(pack4(1, 1, 5, 5), 4'd2, 0, 1'b1, 1'b0);
        cur = "bad_code"; run_route(pack4(5, 0, 0, 0), 4'd3, 2, 1'b0, 1'b0);
        cur = "poke";     run_route(pack4(2, 2, 5, 5), 4'd2, 3, 1'b0, 1'b1);
        cur = "clamp";    run_route('0, 4'd15, 1, 1'b0, 1'b0);

        cur = "reset_mid";
        bus.dir_flat   = pack4(3, 4, 5, 5);
        bus.len_in     = 4'd2;
        bus.path_valid = 1'b1;
        tick();
        bus.path_valid  = 1'b0;
        bus.node_detect = 1'b1;
        tick();
        bus.node_detect = 1'b0;
        tick();
        chk("tv_before", bus.turn_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("tv", bus.turn_valid, 0);
        chk("cmd", bus.turn_cmd, 0);
        chk("ready", bus.path_ready, 1);
        chk("step", bus.step_idx, 0);
        chk("busy", bus.busy, 0);
        chk("follow", bus.follow_en, 0);
        tick();

        cur = "rand";
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < MAX_STEPS; k++) begin
                p = int'($urandom_range(0, 99));
                if (p < 40)      cc = 0;
                else if (p < 85) cc = int'($urandom_range(1, 3));
                else if (p < 93) cc = 4;
                else             cc = int'($urandom_range(5, 7));
                f[k*DIR_W +: DIR_W] = DIR_W'(cc);
            end
            run_route(f, 4'($urandom_range(0, 12)), int'($urandom_range(1, 6)),
                      $urandom_range(0, 3) == 0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
